// File: rtl/spi_loopback_top_p_if.sv
// Parallel-side handshake bundle of the SPI loopback vehicle.
// The requester drives the word, mode and request. The engine returns status and the captured word.
interface spi_loopback_top_p_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] p_dat;
    logic [1:0]        mode;
    logic              tx_en;
    logic              busy;
    logic              tx_done;
    logic [DATA_W-1:0] rcvd_p_dat;
    logic              rcvd_valid;

    modport master (
        output p_dat, mode, tx_en,
        input  busy, tx_done, rcvd_p_dat, rcvd_valid
    );

    modport slave (
        input  p_dat, mode, tx_en,
        output busy, tx_done, rcvd_p_dat, rcvd_valid
    );
endinterface

// File: rtl/spi_loopback_top_p.sv
// SPI master and an internal SPI slave joined MOSI-to-shift-register, all on clk.
// Supports all four {CPOL,CPHA} modes, programmable SCLK rate and bit order.
module spi_loopback_top_p #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_loopback_top_p_if.slave  bus,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs_n
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int HP_W  = $clog2(2 * DATA_W);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [HP_W-1:0]   hp;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] tx_sr;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic [DATA_W-1:0] rcvd_q;

    logic              sclk_prev;
    logic              cs_prev;
    logic [DATA_W-1:0] rx_sr;
    logic [BIT_W-1:0]  rx_cnt;
    logic              sample;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.rcvd_valid = valid_q;
    assign bus.rcvd_p_dat = rcvd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hp      <= '0;
            mode_q  <= '0;
            tx_sr   <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            rcvd_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    sclk <= mode_q[1];
                    if (bus.tx_en) begin
                        mode_q <= bus.mode;
                        tx_sr  <= bus.p_dat;
                        mosi   <= first_bit(bus.p_dat);
                        sclk   <= bus.mode[1];
                        cs_n   <= 1'b0;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        state  <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        hp    <= '0;
                        sclk  <= ~sclk;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (hp == HP_LAST) begin
                            state <= S_TRAIL;
                        end else begin
                            hp   <= hp + 1'b1;
                            sclk <= ~sclk;
                            // Even hp ends on a trailing edge, odd hp on a leading one.
                            if (hp[0] == mode_q[0]) begin
                                tx_sr <= shift_out(tx_sr);
                                mosi  <= first_bit(shift_out(tx_sr));
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        cs_n    <= 1'b1;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        rcvd_q  <= rx_sr;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // cs_prev masks the CPOL jump that coincides with the cs_n fall.
    assign sample = !cs_n && !cs_prev && (sclk != sclk_prev)
                    && ((sclk != mode_q[1]) != mode_q[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            rx_sr     <= '0;
            rx_cnt    <= '0;
        end else begin
            sclk_prev <= sclk;
            cs_prev   <= cs_n;
            if (cs_n) begin
                rx_cnt <= '0;
            end else if (sample && rx_cnt != BIT_FULL) begin
                rx_sr  <= shift_in(rx_sr, mosi);
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_loopback_top_p.sv
// Directed bench for the SPI loopback: an 8-bit mode-programmable instance and a 16-bit LSB-first instance.
module tb_spi_loopback_top_p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk0, mosi0, cs_n0;
    logic sclk1, mosi1, cs_n1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic cur_cpol = 1'b0;

    spi_loopback_top_p_if #(.DATA_W(8))  bus0 ();
    spi_loopback_top_p_if #(.DATA_W(16)) bus1 ();

    spi_loopback_top_p #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0),
        .sclk (sclk0),
        .mosi (mosi0),
        .cs_n (cs_n0)
    );

    spi_loopback_top_p #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut16 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1),
        .sclk (sclk1),
        .mosi (mosi1),
        .cs_n (cs_n1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pulsed 8-bit transfer; rebuilds the serial word from mosi at the slave's sample edges.
    task automatic xfer8(input logic [7:0] d, input logic [1:0] m);
        int   n, rises;
        logic [7:0] word;
        logic prev_sclk, stable, pend, pend_val, done_seen;
        @(negedge clk);
        check("sclk_idle_before", 32'(sclk0), 32'(cur_cpol));
        bus0.p_dat = d;
        bus0.mode  = m;
        bus0.tx_en = 1'b1;
        @(posedge clk); #1;
        bus0.tx_en = 1'b0;
        n = 1;
        check("cs_fall", 32'(cs_n0), 0);
        check("sclk_new_cpol", 32'(sclk0), 32'(m[1]));
        check("first_mosi", 32'(mosi0), 32'(d[7]));
        check("busy_set", 32'(bus0.busy), 1);
        prev_sclk = sclk0; rises = 0; word = '0; stable = 1'b1;
        pend = 1'b0; pend_val = 1'b0; done_seen = 1'b0;
        while (!done_seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (pend && mosi0 !== pend_val) stable = 1'b0;
            pend = 1'b0;
            if (bus0.tx_done) begin
                done_seen = 1'b1;
            end else if (!cs_n0 && sclk0 !== prev_sclk) begin
                if (sclk0) rises++;
                if ((sclk0 != m[1]) != m[0]) begin
                    word     = {word[6:0], mosi0};
                    pend     = 1'b1;
                    pend_val = mosi0;
                end
            end
            prev_sclk = sclk0;
        end
        check("done_cycle", 32'(n), 73);
        check("valid_with_done", 32'(bus0.rcvd_valid), 1);
        check("rcvd_word", 32'(bus0.rcvd_p_dat), 32'(d));
        check("mosi_word", 32'(word), 32'(d));
        check("sclk_rises", 32'(rises), 8);
        check("mosi_stable", 32'(stable), 1);
        check("cs_rise", 32'(cs_n0), 1);
        check("sclk_idle_after", 32'(sclk0), 32'(m[1]));
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus0.tx_done), 0);
        check("busy_clear", 32'(bus0.busy), 0);
        cur_cpol = m[1];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, done1, done2, gap, aborted;
        logic [7:0]  r1, r2;
        logic [15:0] w16;
        logic        p16, seen16;

        // Reset with random inputs
        bus0.p_dat = 8'($urandom);  bus0.mode = 2'($urandom); bus0.tx_en = 1'b1;
        bus1.p_dat = 16'($urandom); bus1.mode = 2'($urandom); bus1.tx_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n0), 1);
        check("rst_sclk", 32'(sclk0), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_tx_done", 32'(bus0.tx_done), 0);
        check("rst_rcvd", 32'(bus0.rcvd_p_dat), 0);
        check("rst_rcvd16", 32'(bus1.rcvd_p_dat), 0);
        bus0.tx_en = 1'b0; bus0.p_dat = '0; bus0.mode = '0;
        bus1.tx_en = 1'b0; bus1.p_dat = '0; bus1.mode = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Mode 0 then modes 1..3
        xfer8(8'h69, 2'b00);
        xfer8(8'hA5, 2'b01);
        xfer8(8'hA5, 2'b10);
        xfer8(8'hA5, 2'b11);

        // tx_en held high, p_dat changed mid-transfer
        @(negedge clk);
        bus0.p_dat = 8'h69; bus0.mode = 2'b00; bus0.tx_en = 1'b1;
        @(posedge clk); #1;
        n = 1; done1 = -1; done2 = -1; gap = 0; r1 = '0; r2 = '0;
        while (done2 < 0 && n < 400) begin
            if (n == 20) bus0.p_dat = 8'h96;
            if (bus0.tx_done) begin
                if (done1 < 0) begin
                    done1 = n; r1 = bus0.rcvd_p_dat;
                end else begin
                    done2 = n; r2 = bus0.rcvd_p_dat; bus0.tx_en = 1'b0;
                end
            end
            if (done1 >= 0 && done2 < 0 && cs_n0) gap++;
            if (done2 < 0) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("held_done1_cycle", 32'(done1), 73);
        check("held_done_spacing", 32'(done2 - done1), 74);
        check("held_rcvd1", 32'(r1), 32'h69);
        check("held_rcvd2", 32'(r2), 32'h96);
        check("held_cs_gap", 32'(gap), 2);
        repeat (3) @(posedge clk);
        #1;
        check("held_stops", 32'(cs_n0), 1);
        cur_cpol = 1'b0;

        // Abort mid-transfer
        @(negedge clk);
        bus0.p_dat = 8'h3C; bus0.mode = 2'b00; bus0.tx_en = 1'b1;
        @(posedge clk); #1;
        bus0.tx_en = 1'b0;
        repeat (29) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n0), 1);
        check("abort_sclk", 32'(sclk0), 0);
        check("abort_busy", 32'(bus0.busy), 0);
        check("abort_rcvd", 32'(bus0.rcvd_p_dat), 0);
        aborted = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus0.tx_done) aborted++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus0.tx_done) aborted++;
        end
        check("abort_no_done", 32'(aborted), 0);
        check("abort_rcvd_held", 32'(bus0.rcvd_p_dat), 0);
        cur_cpol = 1'b0;
        xfer8(8'h3C, 2'b00);

        // 16-bit, CLK_DIV=2, LSB first, mode 3
        @(negedge clk);
        bus1.p_dat = 16'hBEEF; bus1.mode = 2'b11; bus1.tx_en = 1'b1;
        @(posedge clk); #1;
        bus1.tx_en = 1'b0;
        n = 1;
        check("w16_first_mosi", 32'(mosi1), 1);
        check("w16_sclk_cpol", 32'(sclk1), 1);
        w16 = '0; p16 = sclk1; seen16 = 1'b0;
        while (!seen16 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus1.tx_done) seen16 = 1'b1;
            else if (!cs_n1 && sclk1 !== p16 && sclk1 == 1'b1) w16 = {mosi1, w16[15:1]};
            p16 = sclk1;
        end
        check("w16_done_cycle", 32'(n), 69);
        check("w16_valid", 32'(bus1.rcvd_valid), 1);
        check("w16_rcvd", 32'(bus1.rcvd_p_dat), 32'hBEEF);
        check("w16_mosi_word", 32'(w16), 32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
